// File: rtl/decode_stage.sv
// Decode stage: turns a 16-bit instruction into a registered control word and
// holds back instructions whose source registers still await writeback.
module decode_stage #(
   parameter bit WB_BYPASS = 1'b1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] INST_IN,
   input  logic        INST_VALID_IN,
   output logic        INST_READY_OUT,
   input  logic        STALL_IN,
   input  logic        FLUSH_IN,
   input  logic        WB_VALID_IN,
   input  logic [2:0]  WB_AD_IN,
   output logic        VALID_OUT,
   output logic        AR_OUT,
   output logic        BR_OUT,
   output logic [3:0]  ALU_OUT,
   output logic [2:0]  cond_OUT,
   output logic        input_OUT,
   output logic        wren_OUT,
   output logic        ADR_MUX_OUT,
   output logic        write_OUT,
   output logic        PC_load_OUT,
   output logic [2:0]  writeAd_OUT,
   output logic        ILLEGAL_OUT
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_AND   = 4'd3;
   localparam logic [3:0] OP_OR    = 4'd4;
   localparam logic [3:0] OP_ADDI  = 4'd5;
   localparam logic [3:0] OP_LOAD  = 4'd6;
   localparam logic [3:0] OP_STORE = 4'd7;
   localparam logic [3:0] OP_IN    = 4'd8;
   localparam logic [3:0] OP_BR    = 4'd9;

   typedef struct packed {
      logic       ar;
      logic       br;
      logic [3:0] alu;
      logic [2:0] cond;
      logic       in_sel;
      logic       wren;
      logic       adr_mux;
      logic       write;
      logic       pc_load;
      logic [2:0] write_ad;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_ZERO = '{
      ar: 1'b0, br: 1'b0, alu: 4'd0, cond: 3'd0, in_sel: 1'b0, wren: 1'b0,
      adr_mux: 1'b0, write: 1'b0, pc_load: 1'b0, write_ad: 3'd0, illegal: 1'b0
   };

   function automatic logic [7:0] onehot8(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

   logic       valid_q, valid_d;
   ctrl_t      ctrl_q, ctrl_d;
   logic [7:0] busy_q, busy_d;

   ctrl_t      dec_s;
   logic [3:0] op_s;
   logic [2:0] src_a_s, src_b_s;
   logic       src_a_en_s, src_b_en_s;
   logic [7:0] wb_clr_s, busy_view_s, held_mask_s, block_mask_s, set_mask_s;
   logic       hazard_s, ready_s, accept_s, issue_s;

   assign op_s = INST_IN[15:12];

   // Instruction decode into a candidate control word and its source operands
   always_comb begin
      dec_s          = CTRL_ZERO;
      dec_s.write_ad = INST_IN[11:9];
      src_a_s        = INST_IN[8:6];
      src_b_s        = INST_IN[5:3];
      src_a_en_s     = 1'b0;
      src_b_en_s     = 1'b0;
      case (op_s)
         OP_NOP: begin
            dec_s.write_ad = INST_IN[11:9];
         end
         OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            dec_s.ar    = 1'b1;
            dec_s.br    = 1'b1;
            dec_s.write = 1'b1;
            dec_s.alu   = op_s - 4'd1;
            src_a_en_s  = 1'b1;
            src_b_en_s  = 1'b1;
         end
         OP_ADDI: begin
            dec_s.ar    = 1'b1;
            dec_s.write = 1'b1;
            src_a_en_s  = 1'b1;
         end
         OP_LOAD: begin
            dec_s.ar      = 1'b1;
            dec_s.adr_mux = 1'b1;
            dec_s.write   = 1'b1;
            src_a_en_s    = 1'b1;
         end
         OP_STORE: begin
            // the stored data comes from rd, so rd is a read operand here
            dec_s.ar      = 1'b1;
            dec_s.adr_mux = 1'b1;
            dec_s.wren    = 1'b1;
            src_a_en_s    = 1'b1;
            src_b_en_s    = 1'b1;
            src_b_s       = INST_IN[11:9];
         end
         OP_IN: begin
            dec_s.in_sel = 1'b1;
            dec_s.write  = 1'b1;
         end
         OP_BR: begin
            dec_s.pc_load = 1'b1;
            dec_s.cond    = INST_IN[2:0];
         end
         default: begin
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   // Hazard detection and fetch handshake
   always_comb begin
      wb_clr_s    = WB_VALID_IN ? onehot8(WB_AD_IN) : 8'h00;
      busy_view_s = WB_BYPASS ? (busy_q & ~wb_clr_s) : busy_q;
      held_mask_s = (valid_q && ctrl_q.write) ? onehot8(ctrl_q.write_ad) : 8'h00;
      block_mask_s = busy_view_s | held_mask_s;
      hazard_s = (src_a_en_s && block_mask_s[src_a_s]) ||
                 (src_b_en_s && block_mask_s[src_b_s]);
      ready_s  = !FLUSH_IN && (!valid_q || !STALL_IN) && !hazard_s;
      accept_s = ready_s && INST_VALID_IN;
      issue_s  = valid_q && !STALL_IN && !FLUSH_IN;
   end

   assign INST_READY_OUT = ready_s;

   // Output register next state: flush, hold, load or bubble
   always_comb begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_ZERO;
      if (FLUSH_IN) begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_ZERO;
      end else if (valid_q && STALL_IN) begin
         valid_d = valid_q;
         ctrl_d  = ctrl_q;
      end else if (accept_s) begin
         valid_d = 1'b1;
         ctrl_d  = dec_s;
      end else begin
         valid_d = 1'b0;
         ctrl_d  = CTRL_ZERO;
      end
   end

   // Scoreboard next state; a set in the same cycle as a clear wins
   always_comb begin
      set_mask_s = (issue_s && ctrl_q.write) ? onehot8(ctrl_q.write_ad) : 8'h00;
      busy_d     = (busy_q & ~wb_clr_s) | set_mask_s;
   end

   // State registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         valid_q <= 1'b0;
         ctrl_q  <= CTRL_ZERO;
         busy_q  <= 8'h00;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         busy_q  <= busy_d;
      end
   end

   assign VALID_OUT   = valid_q;
   assign AR_OUT      = ctrl_q.ar;
   assign BR_OUT      = ctrl_q.br;
   assign ALU_OUT     = ctrl_q.alu;
   assign cond_OUT    = ctrl_q.cond;
   assign input_OUT   = ctrl_q.in_sel;
   assign wren_OUT    = ctrl_q.wren;
   assign ADR_MUX_OUT = ctrl_q.adr_mux;
   assign write_OUT   = ctrl_q.write;
   assign PC_load_OUT = ctrl_q.pc_load;
   assign writeAd_OUT = ctrl_q.write_ad;
   assign ILLEGAL_OUT = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b1;
   logic [15:0] INST_IN = 16'h0000;
   logic        INST_VALID_IN = 1'b0;
   logic        INST_READY_OUT;
   logic        STALL_IN = 1'b0;
   logic        FLUSH_IN = 1'b0;
   logic        WB_VALID_IN = 1'b0;
   logic [2:0]  WB_AD_IN = 3'd0;
   logic        VALID_OUT, AR_OUT, BR_OUT;
   logic [3:0]  ALU_OUT;
   logic [2:0]  cond_OUT;
   logic        input_OUT, wren_OUT, ADR_MUX_OUT, write_OUT, PC_load_OUT;
   logic [2:0]  writeAd_OUT;
   logic        ILLEGAL_OUT;

   int checks = 0;
   int errors = 0;

   decode_stage dut (
      .CLK(CLK), .RST_N(RST_N), .INST_IN(INST_IN), .INST_VALID_IN(INST_VALID_IN),
      .INST_READY_OUT(INST_READY_OUT), .STALL_IN(STALL_IN), .FLUSH_IN(FLUSH_IN),
      .WB_VALID_IN(WB_VALID_IN), .WB_AD_IN(WB_AD_IN), .VALID_OUT(VALID_OUT),
      .AR_OUT(AR_OUT), .BR_OUT(BR_OUT), .ALU_OUT(ALU_OUT), .cond_OUT(cond_OUT),
      .input_OUT(input_OUT), .wren_OUT(wren_OUT), .ADR_MUX_OUT(ADR_MUX_OUT),
      .write_OUT(write_OUT), .PC_load_OUT(PC_load_OUT), .writeAd_OUT(writeAd_OUT),
      .ILLEGAL_OUT(ILLEGAL_OUT)
   );

   always #5 CLK = ~CLK;

   wire [18:0] ctl = {VALID_OUT, AR_OUT, BR_OUT, ALU_OUT, cond_OUT, input_OUT, wren_OUT,
                      ADR_MUX_OUT, write_OUT, PC_load_OUT, writeAd_OUT, ILLEGAL_OUT};

   function automatic logic [18:0] mk(input logic v, input logic ar, input logic br,
                                      input logic [3:0] alu, input logic [2:0] cnd,
                                      input logic ins, input logic wr, input logic adr,
                                      input logic w, input logic pc, input logic [2:0] wa,
                                      input logic ill);
      return {v, ar, br, alu, cnd, ins, wr, adr, w, pc, wa, ill};
   endfunction

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wb_clear(input logic [2:0] r);
      WB_VALID_IN = 1'b1;
      WB_AD_IN    = r;
      step();
      WB_VALID_IN = 1'b0;
   endtask

   task automatic test_reset();
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if (ctl !== 19'h00000) begin
         errors++; $display("FAIL reset_async ctl got %05h exp %05h", ctl, 19'h00000);
      end
      step(); step();
      RST_N = 1'b1;
      #1;
      checks++;
      if (INST_READY_OUT !== 1'b1) begin
         errors++; $display("FAIL reset_ready got %b exp 1", INST_READY_OUT);
      end
   endtask

   task automatic test_add();
      logic [18:0] exp;
      INST_IN = 16'h1298; INST_VALID_IN = 1'b1;
      step();
      INST_VALID_IN = 1'b0;
      exp = mk(1'b1, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
      checks++;
      if (ctl !== exp) begin
         errors++; $display("FAIL add_word got %05h exp %05h", ctl, exp);
      end
      step();
      checks++;
      if (ctl !== 19'h00000) begin
         errors++; $display("FAIL add_bubble got %05h exp %05h", ctl, 19'h00000);
      end
   endtask

   task automatic test_raw_hazard();
      logic [18:0] exp;
      INST_IN = 16'h2850; INST_VALID_IN = 1'b1;
      #1;
      checks++;
      if (INST_READY_OUT !== 1'b0) begin
         errors++; $display("FAIL raw_blocked got %b exp 0", INST_READY_OUT);
      end
      step();
      checks++;
      if ({VALID_OUT, INST_READY_OUT} !== 2'b00) begin
         errors++; $display("FAIL raw_still_blocked got %b exp 00", {VALID_OUT, INST_READY_OUT});
      end
      WB_VALID_IN = 1'b1; WB_AD_IN = 3'd1;
      #1;
      checks++;
      if (INST_READY_OUT !== 1'b1) begin
         errors++; $display("FAIL raw_bypass_ready got %b exp 1", INST_READY_OUT);
      end
      step();
      WB_VALID_IN = 1'b0; INST_VALID_IN = 1'b0;
      exp = mk(1'b1, 1'b1, 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0);
      checks++;
      if (ctl !== exp) begin
         errors++; $display("FAIL sub_word got %05h exp %05h", ctl, exp);
      end
      step();
      wb_clear(3'd4);
   endtask

   task automatic test_back_to_back();
      logic [15:0] vin [7];
      logic [18:0] vexp [7];
      vin[0] = 16'h5443; vexp[0] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
      vin[1] = 16'h7B80; vexp[1] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 1'b0);
      vin[2] = 16'h67C0; vexp[2] = mk(1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
      vin[3] = 16'h8C00; vexp[3] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 1'b0);
      vin[4] = 16'h4E00; vexp[4] = mk(1'b1, 1'b1, 1'b1, 4'b0011, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 1'b0);
      vin[5] = 16'h9005; vexp[5] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
      vin[6] = 16'h0000; vexp[6] = mk(1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
      INST_VALID_IN = 1'b1;
      for (int i = 0; i < 7; i++) begin
         INST_IN = vin[i];
         #1;
         checks++;
         if (INST_READY_OUT !== 1'b1) begin
            errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, INST_READY_OUT);
         end
         step();
         checks++;
         if (ctl !== vexp[i]) begin
            errors++; $display("FAIL b2b_word[%0d] got %05h exp %05h", i, ctl, vexp[i]);
         end
      end
      INST_VALID_IN = 1'b0;
      step();
      // busy now r2, r3, r6, r7
      INST_IN = 16'h3280; #1;
      checks++;
      if (INST_READY_OUT !== 1'b0) begin
         errors++; $display("FAIL busy_ra got %b exp 0", INST_READY_OUT);
      end
      INST_IN = 16'h7600; #1;
      checks++;
      if (INST_READY_OUT !== 1'b0) begin
         errors++; $display("FAIL busy_store_rd got %b exp 0", INST_READY_OUT);
      end
      INST_IN = 16'h8400; #1;
      checks++;
      if (INST_READY_OUT !== 1'b1) begin
         errors++; $display("FAIL in_no_source got %b exp 1", INST_READY_OUT);
      end
      wb_clear(3'd2); wb_clear(3'd3); wb_clear(3'd6); wb_clear(3'd7);
   endtask

   task automatic test_set_wins();
      INST_IN = 16'h5443; INST_VALID_IN = 1'b1;
      step();
      INST_VALID_IN = 1'b0; WB_VALID_IN = 1'b1; WB_AD_IN = 3'd2;
      step();
      WB_VALID_IN = 1'b0;
      INST_IN = 16'h3280; #1;
      checks++;
      if (INST_READY_OUT !== 1'b0) begin
         errors++; $display("FAIL set_wins got %b exp 0", INST_READY_OUT);
      end
      WB_VALID_IN = 1'b1; WB_AD_IN = 3'd2; #1;
      checks++;
      if (INST_READY_OUT !== 1'b1) begin
         errors++; $display("FAIL wb_bypass got %b exp 1", INST_READY_OUT);
      end
      step();
      WB_VALID_IN = 1'b0;
   endtask

   task automatic test_stall();
      logic [18:0] exp;
      exp = mk(1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0);
      INST_IN = 16'h67C0; INST_VALID_IN = 1'b1;
      step();
      STALL_IN = 1'b1; INST_IN = 16'h8200;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (INST_READY_OUT !== 1'b0) begin
            errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, INST_READY_OUT);
         end
         step();
         checks++;
         if (ctl !== exp) begin
            errors++; $display("FAIL stall_hold[%0d] got %05h exp %05h", i, ctl, exp);
         end
      end
      STALL_IN = 1'b0; INST_VALID_IN = 1'b0;
      step();
      INST_IN = 16'h32C0; #1;
      checks++;
      if ({VALID_OUT, INST_READY_OUT} !== 2'b00) begin
         errors++; $display("FAIL load_busy_after_issue got %b exp 00", {VALID_OUT, INST_READY_OUT});
      end
      wb_clear(3'd3);
   endtask

   task automatic test_flush();
      INST_IN = 16'h9005; INST_VALID_IN = 1'b1;
      step();
      INST_IN = 16'h1298; FLUSH_IN = 1'b1; #1;
      checks++;
      if (INST_READY_OUT !== 1'b0) begin
         errors++; $display("FAIL flush_ready got %b exp 0", INST_READY_OUT);
      end
      step();
      FLUSH_IN = 1'b0; INST_VALID_IN = 1'b0;
      checks++;
      if (ctl !== 19'h00000) begin
         errors++; $display("FAIL flush_bubble got %05h exp %05h", ctl, 19'h00000);
      end
      INST_IN = 16'h5443; INST_VALID_IN = 1'b1;
      step();
      INST_VALID_IN = 1'b0; FLUSH_IN = 1'b1;
      step();
      FLUSH_IN = 1'b0;
      INST_IN = 16'h3280; #1;
      checks++;
      if (INST_READY_OUT !== 1'b1) begin
         errors++; $display("FAIL flush_no_busy got %b exp 1", INST_READY_OUT);
      end
   endtask

   task automatic test_illegal();
      logic [18:0] exp;
      exp = mk(1'b1, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
      INST_IN = 16'hF000; INST_VALID_IN = 1'b1;
      step();
      checks++;
      if (ctl !== exp) begin
         errors++; $display("FAIL illegal_f got %05h exp %05h", ctl, exp);
      end
      INST_IN = 16'hA000;
      step();
      INST_VALID_IN = 1'b0;
      checks++;
      if (ctl !== exp) begin
         errors++; $display("FAIL illegal_a got %05h exp %05h", ctl, exp);
      end
      step();
      checks++;
      if (ctl !== 19'h00000) begin
         errors++; $display("FAIL illegal_drop got %05h exp %05h", ctl, 19'h00000);
      end
   endtask

   task automatic test_reset_mid();
      logic [18:0] exp;
      INST_IN = 16'h5443; INST_VALID_IN = 1'b1;
      step();
      INST_IN = 16'h67C0;
      step();
      STALL_IN = 1'b1; INST_VALID_IN = 1'b0;
      step();
      #3 RST_N = 1'b0;
      #1;
      checks++;
      if (ctl !== 19'h00000) begin
         errors++; $display("FAIL reset_mid_async got %05h exp %05h", ctl, 19'h00000);
      end
      step();
      RST_N = 1'b1; STALL_IN = 1'b0;
      INST_IN = 16'h3280; INST_VALID_IN = 1'b1; #1;
      checks++;
      if (INST_READY_OUT !== 1'b1) begin
         errors++; $display("FAIL reset_mid_ready got %b exp 1", INST_READY_OUT);
      end
      step();
      INST_VALID_IN = 1'b0;
      exp = mk(1'b1, 1'b1, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
      checks++;
      if (ctl !== exp) begin
         errors++; $display("FAIL reset_mid_accept got %05h exp %05h", ctl, exp);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_raw_hazard();
      test_back_to_back();
      test_set_wins();
      test_stall();
      test_flush();
      test_illegal();
      test_reset_mid();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: WB_BYPASS, default 1, when 1 a same-cycle writeback clear unblocks a dependent instruction in that cycle.
REQ-002 CLK  in  1  single clock; all state updates on posedge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 INST_IN  in  16  instruction: [15:12] op, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] imm/cond.
REQ-005 INST_VALID_IN  in  1 / INST_READY_OUT  out  1  fetch handshake; transfer when both high at posedge.
REQ-006 STALL_IN  in  1  downstream cannot accept; FLUSH_IN  in  1  kill pending decode (taken branch).
REQ-007 WB_VALID_IN  in  1 / WB_AD_IN  in  3  writeback of register WB_AD_IN completes this cycle.
REQ-008 VALID_OUT  out  1  registered control word valid.
REQ-009 AR_OUT, BR_OUT  out  1 each  operand A/B from register file (1) or immediate (0).
REQ-010 ALU_OUT  out  4 / cond_OUT  out  3  ALU function / branch condition.
REQ-011 input_OUT, wren_OUT, ADR_MUX_OUT, write_OUT, PC_load_OUT  out  1 each  in-port select, memory write, address mux, register write, PC load.
REQ-012 writeAd_OUT  out  3  destination register; ILLEGAL_OUT  out  1  one-cycle flag for undefined op.

Function
REQ-013 Decode: 0 NOP all zero; 1 ADD ALU=0000; 2 SUB 0001; 3 AND 0010; 4 OR 0011 (1-4: AR=BR=1, write=1); 5 ADDI AR=1 BR=0 ALU=0000 write=1; 6 LOAD AR=1 BR=0 ADR_MUX=1 write=1; 7 STORE AR=1 BR=0 ADR_MUX=1 wren=1; 8 IN input=1 write=1; 9 BR PC_load=1 cond=imm; writeAd=rd for all.
REQ-014 Ops 10-15 decode as NOP with ILLEGAL_OUT=1 while that word is in the output register.
REQ-015 Sources: ops 1-4 read ra,rb; 5,6 read ra; 7 reads ra,rd; 0,8,9 read none.
REQ-016 Scoreboard: 8 busy bits; bit rd set when a word with write=1 issues (VALID_OUT=1 and STALL_IN=0); cleared by WB_VALID_IN for WB_AD_IN.
REQ-017 Simultaneous set and clear of same bit: set wins.
REQ-018 Hazard: a source is busy, or equals writeAd_OUT of a valid write=1 word still held in the output register; with WB_BYPASS=1 a bit being cleared this cycle does not count as busy.
REQ-019 INST_READY_OUT = !FLUSH_IN and (!VALID_OUT or !STALL_IN) and !hazard; combinational from inputs and state.
REQ-020 Latency: accepted instruction appears on outputs, VALID_OUT=1, the next cycle.
REQ-021 STALL_IN=1 with VALID_OUT=1: all outputs held unchanged.
REQ-022 Output register drained with no accept: VALID_OUT=0 and all control outputs 0 (bubble).
REQ-023 FLUSH_IN=1: next cycle VALID_OUT=0, control outputs 0, no accept; a flushed word does not issue and sets no busy bit, even if STALL_IN=0.
REQ-024 FLUSH_IN does not alter busy bits; WB clears still apply.

Reset
REQ-025 RST_N low: immediately VALID_OUT=0, all control outputs 0, writeAd_OUT=0, cond_OUT=0, ILLEGAL_OUT=0, busy bits 0, independent of CLK.
REQ-026 Reset mid-operation discards the held word and all scoreboard state; first accept possible on the first posedge after RST_N rises.

Verification
REQ-027 Reset, INST_IN=0x1298 (ADD r1,r2,r3) valid -> next cycle VALID_OUT=1, ALU=0000, AR=BR=1, write=1, writeAd=1.
REQ-028 ADD r1 issues, then SUB r4,r1,r2 presented -> INST_READY_OUT=0 until WB_VALID_IN with WB_AD_IN=1; with WB_BYPASS=1 accepted in that same cycle.
REQ-029 STALL_IN=1 for 3 cycles with LOAD held -> outputs stable, INST_READY_OUT=0, busy bit for rd not set until STALL_IN falls.
REQ-030 FLUSH_IN with BR (0x9005) in register and ADD valid at input -> next cycle VALID_OUT=0, PC_load=0, ADD not accepted.
REQ-031 INST_IN=0xF000 -> ILLEGAL_OUT=1 one cycle, write=wren=PC_load=0.
REQ-032 RST_N low mid-stall with busy bits set -> outputs 0 asynchronously; after release an instruction reading formerly busy registers is accepted at once.
